usb_tx_scheduler: RTL and testbench
===================================

Name: usb_tx_scheduler

Overview:
Arbitrates the shared USB transmit serial chain (bit stuffer -> NRZI encoder -> DP/DM driver) between NUM_REQ packet sources, such as the protocol FSM and the handshake responder. For the granted requester it sequences SYNC, the payload bytes serialised LSB-first, and EOP. It drives the stuffer's sending/bit inputs and honours the stuffer's stall. It sits directly upstream of the bit stuffer in the sender path.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4
SYNC_BYTE, 8'h80, SYNC pattern, serialised LSB-first (seven 0s, then a 1)

Ports:
clock  in  1  system clock, one bit time per accepted cycle
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  request to transmit; held high until the requester's last byte is acked
req_data  in  8*NUM_REQ  byte from requester i, at bits [8i+7:8i]
req_last  in  NUM_REQ  the presented byte is the final payload byte
byte_ack  out  NUM_REQ  1-cycle pulse: requester's presented byte was captured; present the next byte on the following cycle
gnt  out  NUM_REQ  one-hot grant, held from SYNC start through EOP end
stall  in  1  from bit stuffer: hold the current tx_bit this cycle (stuffed bit being inserted)
tx_bit  out  1  serial bit to the stuffer
tx_sending  out  1  tx_bit valid; equivalent to the stuffer's bs_sending
eop_se0  out  1  drive SE0 on the line
eop_j  out  1  drive the idle J state on the line
busy  out  1  high whenever the block is not in IDLE

Behaviour:
- Reset, synchronous, takes priority over everything, including mid-packet:
  - state=IDLE, gnt=0, byte_ack=0, tx_sending=0, tx_bit=0, eop_se0=0, eop_j=0, busy=0.
  - Round-robin pointer=0; bit counter=0; shift register=0.
- FSM states: IDLE, SYNC, DATA, EOP1, EOP2, EOPJ.
- IDLE:
  - When any req bit is high, grant one round-robin winner, searching upward from the pointer.
  - gnt is registered. Next state is SYNC, so the first SYNC bit appears the cycle after req is seen.
  - The pointer advances to winner+1 modulo NUM_REQ when the grant is issued.
- Accepted bit: any cycle with tx_sending=1 and stall=0. When stall=1, tx_bit, the counter and the shift register all hold. tx_sending stays 1 while stalled.
- SYNC:
  - tx_sending=1; tx_bit = SYNC_BYTE[cnt].
  - On the accepted cycle with cnt=7:
    - Load the shift register from req_data of the granted requester.
    - Latch last_flag from req_last.
    - Pulse byte_ack of the granted requester.
    - Go to DATA with cnt=0.
- DATA:
  - tx_bit = shift[0], which shifts right on each accepted bit.
  - On the accepted cycle with cnt=7:
    - If last_flag=0: reload shift and last_flag from the granted requester and pulse byte_ack (same rule as SYNC). Stay in DATA.
    - If last_flag=1: go to EOP1 with no ack.
- byte_ack fires exactly once per payload byte.
- Requester data is sampled only in ack cycles. Changes at any other time are ignored.
- A req deassertion while granted is ignored; the packet always completes.
- EOP phases ignore stall:
  - EOP1, EOP2: tx_sending=0, eop_se0=1.
  - EOPJ: eop_j=1.
  - Then IDLE with gnt=0.
- A new grant may be issued in the first IDLE cycle after EOPJ, giving a minimum inter-packet gap of 1 cycle.
- Simultaneous requests: only one grant is issued. Losers wait and are served in pointer order.
- busy = (state != IDLE).
- Every output except tx_bit is registered. tx_bit is a combinational mux of registered state.

Optional Feature:
USB_TX_SCHED_PRIO_EN
- Defined: fixed priority, lowest index wins. The round-robin pointer is removed and req[0] always beats the others.
- Undefined: round-robin as described above.
- All other timing is identical in both builds.

Test Plan:
1. Single byte 0xA5 from req[0], last=1, stall=0.
   - Required: gnt=01 the cycle after req.
   - tx_bit = 0,0,0,0,0,0,0,1 then 1,0,1,0,0,1,0,1.
   - byte_ack[0] on the 8th SYNC bit.
   - Then 2 cycles eop_se0, 1 cycle eop_j, busy low.
2. Three bytes 0x01, 0xFF, 0xC3 from req[1]:
   - Exactly 3 byte_ack[1] pulses, spaced 8 accepted bits apart.
   - 24 payload bits, LSB-first, with no gaps.
3. stall high for 1 cycle during the 4th payload bit:
   - tx_bit and the counter hold for that cycle.
   - The packet stretches by exactly 1 cycle; bit order is unchanged.
4. req[0] and req[1] both held for two packets each (default build):
   - Grant order 0,1,0,1.
   - With USB_TX_SCHED_PRIO_EN: grant order 0,0,1,1.
5. reset asserted for 1 cycle mid-DATA:
   - Next cycle all outputs are 0 and state is IDLE.
   - A held req is re-granted starting at requester 0 with a fresh SYNC.
6. req[0] dropped mid-packet:
   - Transmission continues to the byte flagged req_last, and EOP still occurs.

Source files
------------

// File: rtl/usb_tx_scheduler.sv
// rtl/usb_tx_scheduler.sv - arbitrates requesters onto the USB TX bit chain: SYNC, LSB-first payload, EOP
// Build option USB_TX_SCHED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module usb_tx_scheduler #(
    parameter int         NUM_REQ   = 2,
    parameter logic [7:0] SYNC_BYTE = 8'h80
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   byte_ack,
    output logic [NUM_REQ-1:0]   gnt,
    input  logic                 stall,
    output logic                 tx_bit,
    output logic                 tx_sending,
    output logic                 eop_se0,
    output logic                 eop_j,
    output logic                 busy
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_EOP1 = 3'd3;
    localparam logic [2:0] ST_EOP2 = 3'd4;
    localparam logic [2:0] ST_EOPJ = 3'd5;

    logic [2:0]         state;
    logic [2:0]         cnt;
    logic [7:0]         shift;
    logic               last_flag;
    logic [IW-1:0]      gnt_idx;

    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      cand;
    logic [NUM_REQ-1:0] win_onehot;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               accept;
    logic               byte_done;

`ifndef USB_TX_SCHED_PRIO_EN
    logic [IW-1:0]      rr_ptr;
`endif

    // Search from the highest candidate down so the first match in search order is written last.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        win_onehot = '0;
`ifdef USB_TX_SCHED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IW'(i);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
        win_onehot[win_idx] = 1'b1;
    end

    assign sel_data  = req_data[{gnt_idx, 3'b000} +: 8];
    assign sel_last  = req_last[gnt_idx];
    assign accept    = tx_sending & ~stall;
    assign byte_done = accept & (cnt == 3'd7);

    always_comb begin
        tx_bit = 1'b0;
        if (state == ST_SYNC) begin
            tx_bit = SYNC_BYTE[cnt];
        end else if (state == ST_DATA) begin
            tx_bit = shift[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            shift      <= 8'd0;
            last_flag  <= 1'b0;
            gnt_idx    <= '0;
            gnt        <= '0;
            byte_ack   <= '0;
            tx_sending <= 1'b0;
            eop_se0    <= 1'b0;
            eop_j      <= 1'b0;
            busy       <= 1'b0;
`ifndef USB_TX_SCHED_PRIO_EN
            rr_ptr     <= '0;
`endif
        end else begin
            byte_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state      <= ST_SYNC;
                        gnt        <= win_onehot;
                        gnt_idx    <= win_idx;
                        cnt        <= 3'd0;
                        tx_sending <= 1'b1;
                        busy       <= 1'b1;
`ifndef USB_TX_SCHED_PRIO_EN
                        rr_ptr     <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
`endif
                    end
                end
                ST_SYNC: begin
                    if (byte_done) begin
                        shift     <= sel_data;
                        last_flag <= sel_last;
                        byte_ack  <= gnt;
                        cnt       <= 3'd0;
                        state     <= ST_DATA;
                    end else if (accept) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (byte_done) begin
                        cnt <= 3'd0;
                        if (last_flag) begin
                            state      <= ST_EOP1;
                            tx_sending <= 1'b0;
                            eop_se0    <= 1'b1;
                        end else begin
                            shift     <= sel_data;
                            last_flag <= sel_last;
                            byte_ack  <= gnt;
                        end
                    end else if (accept) begin
                        shift <= {1'b0, shift[7:1]};
                        cnt   <= cnt + 3'd1;
                    end
                end
                ST_EOP1: begin
                    state <= ST_EOP2;
                end
                ST_EOP2: begin
                    state   <= ST_EOPJ;
                    eop_se0 <= 1'b0;
                    eop_j   <= 1'b1;
                end
                ST_EOPJ: begin
                    state <= ST_IDLE;
                    eop_j <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    gnt        <= '0;
                    tx_sending <= 1'b0;
                    eop_se0    <= 1'b0;
                    eop_j      <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb/tb_usb_tx_scheduler.sv - randomized self-checking bench for usb_tx_scheduler
module tb_usb_tx_scheduler;

    localparam int N = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_last, byte_ack, gnt;
    logic [8*N-1:0] req_data;
    logic           stall, tx_bit, tx_sending, eop_se0, eop_j, busy;

    always #5 clock = ~clock;

    usb_tx_scheduler #(.NUM_REQ(N), .SYNC_BYTE(8'h80)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
        .byte_ack(byte_ack), .gnt(gnt), .stall(stall), .tx_bit(tx_bit), .tx_sending(tx_sending),
        .eop_se0(eop_se0), .eop_j(eop_j), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester packet store: bytes of all queued packets plus their lengths.
    logic [7:0] bq [N][$];
    int         lenq [N][$];
    int         pos [N];
    bit         drop [N];

    int  stall_mode = 0;
    bit  stall_done = 0;
    bit  reset_req = 0;
    bit  reset_applied;

    // Reference model of one packet on the line.
    bit         in_pkt = 0;
    int         cur_w, exp_len, acks, wrong_acks, se0_cnt, j_cnt, stall_cnt, busy_cycles;
    bit         exp_bits[$];
    bit         obs_bits[$];
    int         grants[$];
    int         model_ptr = 0;
    logic [N-1:0] req_applied;
    bit         busy_prev = 0;
    bit         stall_prev_sending = 0;
    logic       tx_bit_prev = 1'b0;
    logic [7:0] sync_pat = 8'h80;

    function automatic int pick_winner(input logic [N-1:0] r);
`ifdef USB_TX_SCHED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 0; k < N; k++) if (r[(model_ptr + k) % N]) return (model_ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic start_packet(input int w);
        logic [7:0] b;
        logic [N-1:0] onehot;
        onehot = '0;
        onehot[w] = 1'b1;
        check_val("grant_onehot", gnt, onehot);
        check_val("grant_busy", busy, 1);
        check_val("grant_sync_start", tx_sending, 1);
        cur_w = w;
        exp_len = lenq[w][0];
        exp_bits.delete();
        obs_bits.delete();
        for (int k = 0; k < 8; k++) exp_bits.push_back(sync_pat[k]);
        for (int j = 0; j < exp_len; j++) begin
            b = bq[w][j];
            for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
        end
        acks = 0; wrong_acks = 0; se0_cnt = 0; j_cnt = 0; stall_cnt = 0; busy_cycles = 0;
        in_pkt = 1;
        grants.push_back(w);
`ifndef USB_TX_SCHED_PRIO_EN
        model_ptr = (w + 1) % N;
`endif
    endtask

    task automatic finish_packet();
        check_val("end_gnt_clear", gnt, 0);
        check_val("bit_count", obs_bits.size(), exp_bits.size());
        for (int k = 0; k < exp_bits.size() && k < obs_bits.size(); k++)
            check_val($sformatf("bit[%0d]", k), obs_bits[k], exp_bits[k]);
        check_val("ack_count", acks, exp_len);
        check_val("foreign_acks", wrong_acks, 0);
        check_val("se0_cycles", se0_cnt, 2);
        check_val("j_cycles", j_cnt, 1);
        check_val("pkt_cycles", busy_cycles, exp_bits.size() + stall_cnt + 3);
        in_pkt = 0;
    endtask

    task automatic cycle();
        logic [N-1:0] onehot;
        bit stall_new;
        @(negedge clock);
        if (reset_applied) begin
            check_val("rst_gnt", gnt, 0);
            check_val("rst_ack", byte_ack, 0);
            check_val("rst_sending", tx_sending, 0);
            check_val("rst_bit", tx_bit, 0);
            check_val("rst_se0", eop_se0, 0);
            check_val("rst_j", eop_j, 0);
            check_val("rst_busy", busy, 0);
            in_pkt = 0;
            model_ptr = 0;
            for (int i = 0; i < N; i++) pos[i] = 0;
        end else begin
            if (!busy_prev && req_applied != '0) begin
                start_packet(pick_winner(req_applied));
            end else if (!busy_prev) begin
                check_val("idle_busy", busy, 0);
                check_val("idle_gnt", gnt, 0);
            end
            if (in_pkt) begin
                if (busy) busy_cycles++;
                if (stall_prev_sending) begin
                    check_val("stall_hold_bit", tx_bit, tx_bit_prev);
                    check_val("stall_hold_send", tx_sending, 1);
                end
                onehot = '0;
                onehot[cur_w] = 1'b1;
                if (byte_ack[cur_w]) acks++;
                if ((byte_ack & ~onehot) != '0) wrong_acks++;
                if (eop_se0) begin
                    se0_cnt++;
                    check_val("se0_not_sending", tx_sending, 0);
                end
                if (eop_j) j_cnt++;
                if (busy_prev && !busy) finish_packet();
            end
        end

        for (int i = 0; i < N; i++) begin
            if (byte_ack[i] && lenq[i].size() > 0) begin
                pos[i]++;
                if (pos[i] == lenq[i][0]) begin
                    repeat (lenq[i][0]) void'(bq[i].pop_front());
                    void'(lenq[i].pop_front());
                    pos[i] = 0;
                    drop[i] = 0;
                end
            end
        end

        stall_new = 0;
        if (stall_mode == 1) stall_new = ($urandom_range(0, 5) == 0);
        if (stall_mode == 2 && in_pkt && tx_sending && obs_bits.size() == 11 && !stall_done) begin
            stall_new = 1;
            stall_done = 1;
        end
        if (in_pkt && tx_sending && !reset_req) begin
            if (stall_new) stall_cnt++;
            else obs_bits.push_back(tx_bit);
        end
        stall_prev_sending = tx_sending && stall_new && !reset_req;
        tx_bit_prev = tx_bit;
        busy_prev = reset_applied ? 1'b0 : busy;

        stall = stall_new;
        reset = reset_req;
        reset_applied = reset_req;
        for (int i = 0; i < N; i++) begin
            if (lenq[i].size() > 0) begin
                req[i] = !drop[i];
                req_data[8*i +: 8] = bq[i][pos[i]];
                req_last[i] = (pos[i] == lenq[i][0] - 1);
            end else begin
                req[i] = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
        req_applied = reset_req ? '0 : req;
    endtask

    task automatic add_pkt(input int i, input int len, input logic [31:0] bytes);
        for (int k = 0; k < len; k++) bq[i].push_back(bytes[8*k +: 8]);
        lenq[i].push_back(len);
    endtask

    task automatic wait_idle(input int budget);
        int waited;
        waited = 0;
        while ((lenq[0].size() + lenq[1].size() != 0 || busy || in_pkt) && waited < budget) begin
            cycle();
            waited++;
        end
        if (waited >= budget)
            check_val("wait_timeout", lenq[0].size() + lenq[1].size() + busy + in_pkt, 0);
    endtask

    task automatic wait_payload(input int min_bits, input int min_grants, input int budget);
        int waited;
        waited = 0;
        while (!(in_pkt && obs_bits.size() >= min_bits && grants.size() >= min_grants) && waited < budget) begin
            cycle();
            waited++;
        end
        if (waited >= budget) check_val("payload_timeout", obs_bits.size(), min_bits);
    endtask

    task automatic do_reset();
        reset_req = 1;
        cycle();
        reset_req = 0;
        cycle();
    endtask

    int exp_order[4];

    initial begin
        reset = 1'b1; reset_applied = 1'b1;
        req = '0; req_data = '0; req_last = '0; stall = 1'b0; req_applied = '0;
        for (int i = 0; i < N; i++) begin pos[i] = 0; drop[i] = 0; end
        do_reset();

        add_pkt(0, 1, 32'h000000A5);
        wait_idle(200);

        add_pkt(1, 3, 32'h00C3FF01);
        wait_idle(300);

        stall_mode = 2; stall_done = 0;
        add_pkt(0, 2, 32'h00005A96);
        wait_idle(300);
        stall_mode = 0;

        do_reset();
        grants.delete();
        add_pkt(0, 1, 32'h11); add_pkt(0, 2, 32'h2233);
        add_pkt(1, 1, 32'h44); add_pkt(1, 1, 32'h55);
        wait_idle(1000);
`ifdef USB_TX_SCHED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        check_val("arb_grants", grants.size(), 4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            check_val($sformatf("arb_order[%0d]", k), grants[k], exp_order[k]);

        do_reset();
        grants.delete();
        add_pkt(0, 1, 32'h3C); add_pkt(0, 2, 32'hE718);
        add_pkt(1, 3, 32'h00B24D);
        wait_payload(12, 2, 400);
        reset_req = 1;
        cycle();
        reset_req = 0;
        grants.delete();
        wait_payload(0, 1, 50);
        if (grants.size() > 0) check_val("rst_regrant", grants[0], 0);
        wait_idle(1000);

        add_pkt(0, 3, 32'h00F00F69);
        wait_payload(14, 0, 200);
        drop[0] = 1;
        wait_idle(300);

        stall_mode = 1;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1 || i == it % N)
                    add_pkt(i, $urandom_range(1, 4), $urandom);
            wait_idle(3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
